// File: rtl/timer_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | timer_pkg : shared types and default widths for the timer timebase |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
package timer_pkg;

  localparam int CNT_W_D = 8;
  localparam int PSC_W_D = 8;

  typedef enum logic [1:0] {
    DIR_UP   = 2'b00,
    DIR_DOWN = 2'b01,
    DIR_UPDN = 2'b10
  } dir_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } cnt_state_e;

endpackage
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | timer_prescaler : divides pclk by prescale+1 into counter strobes   |
// | Revision        : 1.0                                              |
// +--------------------------------------------------------------------+
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int PSC_W = PSC_W_D
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             i_enable,
  input  logic             i_clear,
  input  logic [PSC_W-1:0] i_prescale,
  output logic             o_fire,
  output logic             o_tick
);

  localparam logic [PSC_W-1:0] c_one = PSC_W'(1);

  logic [PSC_W-1:0] r_psc;
  logic             r_tick;
  logic             w_fire;

  // >= rather than == so a prescale lowered below the running count wraps at once
  assign w_fire = i_enable && !i_clear && (r_psc >= i_prescale);
  assign o_fire = w_fire;
  assign o_tick = r_tick;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_psc  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_fire;
      if (i_clear) begin
        r_psc <= '0;
      end else if (i_enable) begin
        r_psc <= w_fire ? '0 : (r_psc + c_one);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/timer_counter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | timer_counter : prescaled up/down/up-down timebase with match flags |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
module timer_counter
  import timer_pkg::*;
#(
  parameter int NUM_COMP = 3,
  parameter int CNT_W    = CNT_W_D,
  parameter int PSC_W    = PSC_W_D
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic                      i_en,
  input  logic                      i_start,
  input  logic                      i_stop,
  input  logic                      i_one_shot,
  input  logic [1:0]                i_dir_mode,
  input  logic [PSC_W-1:0]          i_prescale,
  input  logic [CNT_W-1:0]          i_period,
  input  logic [NUM_COMP*CNT_W-1:0] i_match_value,
  input  logic [NUM_COMP-1:0]       i_flag_clr,
  input  logic                      i_ovf_clr,
  output logic [CNT_W-1:0]          o_counter_value,
  output logic [NUM_COMP-1:0]       o_flag,
  output logic                      o_ovf_flag,
  output logic                      o_tick,
  output logic                      o_running
);

  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  cnt_state_e          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_dir_up;
  logic                r_ovf;
  logic                r_running;
  logic [NUM_COMP-1:0] r_match_prev;
  logic [NUM_COMP-1:0] r_flag;

  logic                w_mode_down;
  logic                w_mode_updn;
  logic                w_load;
  logic                w_count_en;
  logic                w_fire;
  logic                w_tick;
  logic [CNT_W-1:0]    w_load_val;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_dir_up_nxt;
  logic                w_ovf_evt;
  logic [NUM_COMP-1:0] w_match_now;

  // Mode 2'b11 falls through to plain up counting
  assign w_mode_down = (i_dir_mode == DIR_DOWN);
  assign w_mode_updn = (i_dir_mode == DIR_UPDN);
  assign w_load_val  = w_mode_down ? i_period : '0;

  assign w_load     = i_start && !i_stop && ((r_state == IDLE) || (r_state == RUN));
  assign w_count_en = (r_state == RUN) && i_en && !i_start && !i_stop;

  timer_prescaler #(
    .PSC_W (PSC_W)
  ) u_prescaler (
    .pclk       (pclk),
    .presetn    (presetn),
    .i_enable   (w_count_en),
    .i_clear    (w_load),
    .i_prescale (i_prescale),
    .o_fire     (w_fire),
    .o_tick     (w_tick)
  );

  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_dir_up_nxt = r_dir_up;
    w_ovf_evt    = 1'b0;
    if (w_fire) begin
      if (w_mode_down) begin
        if (r_cnt == '0) begin
          w_cnt_nxt = i_period;
          w_ovf_evt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - c_one;
        end
      end else if (w_mode_updn) begin
        if (i_period == '0) begin
          w_cnt_nxt    = '0;
          w_dir_up_nxt = 1'b1;
          w_ovf_evt    = 1'b1;
        end else if (r_dir_up) begin
          // Turn around at the top without dwelling on period
          if (r_cnt >= i_period) begin
            w_cnt_nxt    = i_period - c_one;
            w_dir_up_nxt = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt + c_one;
          end
        end else if (r_cnt == '0) begin
          w_cnt_nxt    = c_one;
          w_dir_up_nxt = 1'b1;
          w_ovf_evt    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - c_one;
        end
      end else begin
        if (r_cnt >= i_period) begin
          w_cnt_nxt = '0;
          w_ovf_evt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_one;
        end
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_dir_up  <= 1'b1;
      r_ovf     <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_ovf <= w_ovf_evt | (r_ovf & ~i_ovf_clr);
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_state   <= RUN;
            r_running <= 1'b1;
            r_cnt     <= w_load_val;
            r_dir_up  <= 1'b1;
          end
        end
        RUN: begin
          if (i_stop) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
          end else if (i_start) begin
            r_cnt    <= w_load_val;
            r_dir_up <= 1'b1;
          end else if (!i_en) begin
            r_state <= PAUSE;
          end else begin
            r_cnt    <= w_cnt_nxt;
            r_dir_up <= w_dir_up_nxt;
            if (w_ovf_evt && i_one_shot) begin
              r_state   <= IDLE;
              r_running <= 1'b0;
            end
          end
        end
        PAUSE: begin
          if (i_stop) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
          end else if (i_en) begin
            r_state <= RUN;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_COMP; g++) begin : g_match
    assign w_match_now[g] = (r_state == RUN) && (r_cnt == i_match_value[g*CNT_W +: CNT_W]);
  end

  // History freezes in PAUSE so a counter parked on a match value flags only once
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_match_prev <= '0;
      r_flag       <= '0;
    end else begin
      if (r_state != PAUSE) begin
        r_match_prev <= w_match_now;
      end
      r_flag <= (w_match_now & ~r_match_prev) | (r_flag & ~i_flag_clr);
    end
  end

  assign o_counter_value = r_cnt;
  assign o_flag          = r_flag;
  assign o_ovf_flag      = r_ovf;
  assign o_tick          = w_tick;
  assign o_running       = r_running;

endmodule
`default_nettype wire

// File: tb/tb_timer_counter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | tb_timer_counter : directed scoreboard bench for timer_counter      |
// | Revision         : 1.0                                             |
// +--------------------------------------------------------------------+
module tb_timer_counter;

  localparam int NC = 3;
  localparam int CW = 8;
  localparam int PW = 8;

  logic           pclk = 1'b0;
  logic           presetn;
  logic           en, start, stop, one_shot, ovf_clr;
  logic [1:0]     dir_mode;
  logic [PW-1:0]  prescale;
  logic [CW-1:0]  period;
  logic [NC*CW-1:0] match_value;
  logic [NC-1:0]  flag_clr;
  logic [CW-1:0]  counter_value;
  logic [NC-1:0]  flag;
  logic           ovf_flag, tick, running;

  int total = 0;
  int bad   = 0;
  logic [CW-1:0] exp_q[$];

  timer_counter #(
    .NUM_COMP (NC),
    .CNT_W    (CW),
    .PSC_W    (PW)
  ) dut (
    .pclk            (pclk),
    .presetn         (presetn),
    .i_en            (en),
    .i_start         (start),
    .i_stop          (stop),
    .i_one_shot      (one_shot),
    .i_dir_mode      (dir_mode),
    .i_prescale      (prescale),
    .i_period        (period),
    .i_match_value   (match_value),
    .i_flag_clr      (flag_clr),
    .i_ovf_clr       (ovf_clr),
    .o_counter_value (counter_value),
    .o_flag          (flag),
    .o_ovf_flag      (ovf_flag),
    .o_tick          (tick),
    .o_running       (running)
  );

  always #5 pclk = ~pclk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
    logic [CW-1:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(counter_value), 32'(e));
    end
  endtask

  initial begin
    presetn = 1'b0; en = 1'b0; start = 1'b0; stop = 1'b0; one_shot = 1'b0;
    ovf_clr = 1'b0; dir_mode = 2'b00; prescale = '0; period = '0;
    match_value = {8'd200, 8'd200, 8'd200}; flag_clr = '0;
    repeat (2) step();
    chk("rst_cnt",     32'(counter_value), 32'd0);
    chk("rst_flag",    32'(flag),          32'd0);
    chk("rst_ovf",     32'(ovf_flag),      32'd0);
    chk("rst_tick",    32'(tick),          32'd0);
    chk("rst_running", 32'(running),       32'd0);
    presetn = 1'b1;
    step();

    // Up, prescale 0, period 4: wrap after 4
    en = 1'b1; period = 8'd4;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k <= 4; k++) exp_q.push_back(8'(k));
    exp_q.push_back(8'd0);
    chk_cnt("t1_load");
    chk("t1_running", 32'(running), 32'd1);
    for (int k = 1; k < 6; k++) begin
      if (k == 5) chk("t1_ovf_pre", 32'(ovf_flag), 32'd0);
      step();
      chk_cnt("t1_cnt");
      chk("t1_tick", 32'(tick), 32'd1);
    end
    chk("t1_ovf", 32'(ovf_flag), 32'd1);
    step();
    stop = 1'b1; step(); stop = 1'b0;
    exp_q.push_back(8'd1);
    chk_cnt("t1_stop_hold");
    chk("t1_stop_running", 32'(running), 32'd0);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("t1_ovf_clr", 32'(ovf_flag), 32'd0);

    // Prescale 2 with a 5-cycle pause
    prescale = 8'd2; period = 8'd255;
    start = 1'b1; step(); start = 1'b0;
    exp_q.push_back(8'd0);
    chk_cnt("t2_load");
    exp_q.push_back(8'd0); exp_q.push_back(8'd0); exp_q.push_back(8'd1);
    exp_q.push_back(8'd1); exp_q.push_back(8'd1); exp_q.push_back(8'd2);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk_cnt("t2_cnt");
      chk("t2_tick", 32'(tick), (k % 3 == 0) ? 32'd1 : 32'd0);
    end
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      exp_q.push_back(8'd2);
      chk_cnt("t2_pause_cnt");
      chk("t2_pause_running", 32'(running), 32'd1);
      chk("t2_pause_tick", 32'(tick), 32'd0);
    end
    en = 1'b1;
    exp_q.push_back(8'd2); exp_q.push_back(8'd2); exp_q.push_back(8'd2); exp_q.push_back(8'd3);
    for (int k = 0; k < 4; k++) begin
      step();
      chk_cnt("t2_resume");
    end
    stop = 1'b1; step(); stop = 1'b0;

    // Down, one-shot, period 3
    dir_mode = 2'b01; period = 8'd3; one_shot = 1'b1; prescale = '0;
    start = 1'b1; step(); start = 1'b0;
    exp_q.push_back(8'd3);
    chk_cnt("t3_load");
    exp_q.push_back(8'd2); exp_q.push_back(8'd1); exp_q.push_back(8'd0); exp_q.push_back(8'd3);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) chk("t3_ovf_pre", 32'(ovf_flag), 32'd0);
      step();
      chk_cnt("t3_cnt");
    end
    chk("t3_running", 32'(running), 32'd0);
    chk("t3_ovf", 32'(ovf_flag), 32'd1);
    step();
    exp_q.push_back(8'd3);
    chk_cnt("t3_idle_hold");
    one_shot = 1'b0;
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;

    // Up-down, period 2
    dir_mode = 2'b10; period = 8'd2;
    start = 1'b1; step(); start = 1'b0;
    exp_q.push_back(8'd0);
    chk_cnt("t4_load");
    exp_q.push_back(8'd1); exp_q.push_back(8'd2); exp_q.push_back(8'd1);
    exp_q.push_back(8'd0); exp_q.push_back(8'd1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk_cnt("t4_cnt");
      chk("t4_ovf", 32'(ovf_flag), (k == 4) ? 32'd1 : 32'd0);
    end
    stop = 1'b1; step(); stop = 1'b0;

    // Match flag on channel 1
    dir_mode = 2'b00; period = 8'd255; match_value = {8'd200, 8'd5, 8'd200};
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k <= 5; k++) exp_q.push_back(8'(k));
    chk_cnt("t5_load");
    for (int k = 0; k < 5; k++) begin
      step();
      chk_cnt("t5_cnt");
    end
    chk("t5_flag_pre", 32'(flag), 32'd0);
    step();
    chk("t5_flag_set", 32'(flag), 32'b010);
    flag_clr = 3'b010; step(); flag_clr = '0;
    chk("t5_flag_clr", 32'(flag), 32'd0);
    start = 1'b1; step(); start = 1'b0;
    repeat (5) step();
    exp_q.push_back(8'd5);
    chk_cnt("t5_cnt5_again");
    flag_clr = 3'b010; step(); flag_clr = '0;
    chk("t5_set_beats_clr", 32'(flag), 32'b010);

    // Reload clears prescaler; start+stop together stops
    prescale = 8'd2;
    start = 1'b1; step(); start = 1'b0;
    for (int n = 0; n < 100 && counter_value != 8'd7; n++) step();
    chk("t6_reach7", 32'(counter_value), 32'd7);
    step();
    start = 1'b1; step(); start = 1'b0;
    exp_q.push_back(8'd0); exp_q.push_back(8'd0); exp_q.push_back(8'd0); exp_q.push_back(8'd1);
    chk_cnt("t6_reload");
    for (int k = 0; k < 3; k++) begin
      step();
      chk_cnt("t6_psc_cleared");
    end
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk("t6_stop_wins", 32'(running), 32'd0);
    exp_q.push_back(8'd1);
    chk_cnt("t6_stop_hold");

    // Asynchronous reset mid-run
    prescale = '0; ovf_clr = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    repeat (3) step();
    #2 presetn = 1'b0;
    #1;
    chk("ar_cnt",     32'(counter_value), 32'd0);
    chk("ar_ovf",     32'(ovf_flag),      32'd0);
    chk("ar_flag",    32'(flag),          32'd0);
    chk("ar_tick",    32'(tick),          32'd0);
    chk("ar_running", 32'(running),       32'd0);
    step();
    presetn = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Programmable timebase feeding the timer's compare/PWM stage; produces `counter_value` plus sticky per-comparator match flags and an overflow flag.
- Includes a prescaler, up/down/up-down count modes, continuous or one-shot operation, and pause/stop control.
- Sits between the APB register file (control inputs, write-1-to-clear pulses) and the compare/PWM block, which consumes `counter_value` and `flag`.

Parameters:
- NUM_COMP, 3: number of compare channels.
- CNT_W, 8: counter width.
- PSC_W, 8: prescaler width.

Ports:
- pclk  in  1  clock; all state on rising edge.
- presetn  in  1  asynchronous active-low reset.
- en  in  1  run enable; low pauses counting.
- start  in  1  one-cycle pulse: (re)load and begin counting.
- stop  in  1  one-cycle pulse: return to IDLE.
- one_shot  in  1  1 = stop after first overflow event.
- dir_mode  in  2  00 up, 01 down, 10 up-down, 11 treated as up.
- prescale  in  PSC_W  tick every prescale+1 pclk cycles.
- period  in  CNT_W  top count value.
- match_value  in  NUM_COMP x CNT_W  compare values.
- flag_clr  in  NUM_COMP  write-1-to-clear pulses for flag.
- ovf_clr  in  1  write-1-to-clear pulse for ovf_flag.
- counter_value  out  CNT_W  current count.
- flag  out  NUM_COMP  sticky match flags.
- ovf_flag  out  1  sticky overflow/underflow flag.
- tick  out  1  one-cycle pulse at each counter update opportunity.
- running  out  1  high in RUN or PAUSE.

Behaviour:
- Reset values: counter_value=0, flag=0, ovf_flag=0, tick=0, running=0, prescaler=0, state=IDLE, internal direction=up.
- States: IDLE, RUN, PAUSE.
- IDLE: counter holds its value.
  - start -> RUN.
  - Counter loads 0 for up/up-down, or period for down. Prescaler clears. Up-down direction is set to up.
- RUN:
  - en=0 -> PAUSE; counter and prescaler freeze.
  - stop -> IDLE; counter retained.
  - start -> reload exactly as from IDLE.
- PAUSE:
  - en=1 -> RUN; resume from the frozen values.
  - stop -> IDLE.
- Simultaneous start and stop: stop wins.
- Prescaler (RUN only):
  - When psc >= prescale: psc wraps to 0 and a tick is generated. Otherwise psc increments.
  - The >= comparison means lowering prescale mid-run never causes a 2^PSC_W stall.
  - prescale=0: tick every cycle.
- Register timing: tick is registered and high in the same cycle counter_value shows the updated value.
- Count update on each tick:
  - Up: if cnt >= period, cnt<=0 and overflow event; else cnt+1.
  - Down: if cnt==0, cnt<=period and overflow event; else cnt-1.
  - Up-down: counts up to period, then down to 0. Direction reverses at each endpoint. Overflow event only on the 0 reversal.
  - period=0: counter stays 0 and every tick is an overflow event.
- Overflow handling: each event sets ovf_flag. If one_shot=1, the state goes to IDLE in the same update and the counter holds its post-wrap value.
- Match flags:
  - match_now[i] = (counter_value == match_value[i]) while state is RUN.
  - flag[i] sets one cycle after a rising edge of match_now[i]; edge history resets to 0.
  - A counter that holds on a match value (PAUSE) sets the flag only once.
- Clear priority: a set and a clear in the same cycle leave the flag set. The same rule applies to ovf_flag.
- Reset mid-operation: everything returns immediately to reset values.

Decomposition:
- Package timer_pkg:
  - dir_mode_e {DIR_UP=2'b00, DIR_DOWN=2'b01, DIR_UPDN=2'b10}.
  - cnt_state_e {IDLE, RUN, PAUSE}.
  - Default widths CNT_W_D=8 and PSC_W_D=8.
- One sub-module, timer_prescaler: inputs enable, clear, and prescale; output tick.

Test Plan:
- Reset, then start with dir=up, prescale=0, period=4 -> counter 0,1,2,3,4,0 on consecutive cycles; ovf_flag sets on the wrap; tick high every cycle.
- prescale=2, up, period=255 -> counter increments every 3rd cycle. en=0 for 5 cycles freezes counter and prescaler; running stays 1.
- Down, period=3, one_shot=1 -> counter 3,2,1,0,3; state returns to IDLE with running=0 and counter=3; ovf_flag=1.
- Up-down, period=2 -> counter 0,1,2,1,0,1; ovf_flag sets only at the 0 turnaround.
- match_value[1]=5, up count -> flag[1] rises one cycle after counter_value=5. flag_clr[1] clears it. flag_clr[1] asserted in the set cycle leaves flag[1]=1.
- start and stop in the same cycle during RUN -> IDLE. start alone at cnt=7 -> counter reloads 0 and prescaler clears.
